// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// bus_arbiter : registered round-robin arbiter for four masters, with
//               active-low requests/grants and an optional bus-tenure limit.
// Revision    : 1.0
// ============================================================================
module bus_arbiter #(
    parameter int unsigned MAX_HOLD = 0,
    parameter int unsigned HOLD_W   = 8
) (
    input  logic       clk,
    input  logic       reset_,
    input  logic       m0Req_,
    input  logic       m1Req_,
    input  logic       m2Req_,
    input  logic       m3Req_,
    output logic       m0Grnt_,
    output logic       m1Grnt_,
    output logic       m2Grnt_,
    output logic       m3Grnt_,
    output logic [1:0] owner
);

    localparam bit                C_LIMIT_EN  = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] C_HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    logic [3:0]        req;
    logic [3:0]        others;
    logic [1:0]        cand;
    logic              cand_vld;
    logic [1:0]        owner_q;
    logic [1:0]        owner_d;
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_d;

    assign req    = ~{m3Req_, m2Req_, m1Req_, m0Req_};
    assign others = req & ~(4'b0001 << owner_q);

    // Scan from the farthest offset down so the nearest requester after the
    // owner is the one left in cand.
    always_comb begin
        cand     = owner_q;
        cand_vld = 1'b0;
        for (int k = 3; k >= 1; k--) begin
            if (others[owner_q + 2'(k)]) begin
                cand     = owner_q + 2'(k);
                cand_vld = 1'b1;
            end
        end
    end

    always_comb begin
        owner_d = owner_q;
        hold_d  = '0;
        if (cand_vld) begin
            if (!req[owner_q] || (C_LIMIT_EN && (hold_q >= C_HOLD_LAST))) begin
                owner_d = cand;
            end else begin
                hold_d = (hold_q == '1) ? hold_q : hold_q + HOLD_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            owner_q <= 2'd0;
            hold_q  <= '0;
        end else begin
            owner_q <= owner_d;
            hold_q  <= hold_d;
        end
    end

    // Grants decode only the registered owner, so exactly one is ever low.
    assign m0Grnt_ = (owner_q != 2'd0);
    assign m1Grnt_ = (owner_q != 2'd1);
    assign m2Grnt_ = (owner_q != 2'd2);
    assign m3Grnt_ = (owner_q != 2'd3);
    assign owner   = owner_q;

endmodule
`default_nettype wire
